// File: rtl/image_write_if.sv
// Pixel-stream sink bundle: two-pixel RGB beats in, byte stream with valid/ready out.
`timescale 1ns/1ps
interface image_write_if;
    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] DATA_R1;
    logic [7:0] DATA_G1;
    logic [7:0] DATA_B1;
    logic       frame_done;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       drain_done;
    logic       err_overrun;

    modport master (
        output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, byte_ready,
        input  frame_done, byte_out, byte_valid, drain_done, err_overrun
    );

    modport slave (
        input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, byte_ready,
        output frame_done, byte_out, byte_valid, drain_done, err_overrun
    );
endinterface

// File: rtl/image_write.sv
// Captures one two-pixel-per-beat frame bottom-up into a beat buffer, then drains it
// as R,G,B bytes per pixel through a valid/ready handshake.
`timescale 1ns/1ps
module image_write #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    image_write_if.slave  vif
);
    localparam int BEATS = WIDTH * HEIGHT / 2;
    localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IDX_W = (BEATS  > 1) ? $clog2(BEATS)  : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t             state_reg;
    logic [ROW_W-1:0]   row_reg;
    logic [COL_W-1:0]   col_reg;
    logic [IDX_W-1:0]   rd_idx_reg;
    logic [2:0]         byte_sel_reg;
    logic [47:0]        cur_entry_reg;
    logic               cur_last_reg;
    logic               q_ok_reg;
    logic               byte_valid_reg;
    logic               frame_done_reg;
    logic               drain_done_reg;
    logic               err_overrun_reg;

    logic [47:0]        mem [0:BEATS-1];
    logic [47:0]        rd_q_reg;
    logic [IDX_W-1:0]   wr_addr;
    logic [47:0]        wr_data;
    logic               wr_en;
    logic               last_beat;
    logic               handshake;
    logic               do_load;
    logic [7:0]         byte_mux;

    always_comb begin
        wr_addr   = IDX_W'((HEIGHT - 1 - int'(row_reg)) * (WIDTH / 2) + int'(col_reg) / 2);
        wr_data   = {vif.DATA_R0, vif.DATA_G0, vif.DATA_B0, vif.DATA_R1, vif.DATA_G1, vif.DATA_B1};
        wr_en     = (state_reg == CAPTURE) && vif.HSYNC && !vif.VSYNC;
        last_beat = (row_reg == ROW_W'(HEIGHT - 1)) && (col_reg == COL_W'(WIDTH - 2));
        handshake = byte_valid_reg && vif.byte_ready;
        // rd_q_reg is only trusted once q_ok_reg says the address has been stable a cycle
        do_load   = (state_reg == DRAIN) && q_ok_reg &&
                    (!byte_valid_reg || (handshake && byte_sel_reg == 3'd5 && !cur_last_reg));
    end

    // Buffer: write port from capture, registered read addressed by the drain pointer
    always_ff @(posedge HCLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q_reg <= mem[rd_idx_reg];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg       <= IDLE;
            row_reg         <= '0;
            col_reg         <= '0;
            rd_idx_reg      <= '0;
            byte_sel_reg    <= '0;
            cur_entry_reg   <= '0;
            cur_last_reg    <= 1'b0;
            q_ok_reg        <= 1'b0;
            byte_valid_reg  <= 1'b0;
            frame_done_reg  <= 1'b0;
            drain_done_reg  <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            drain_done_reg <= 1'b0;
            if (vif.HSYNC && state_reg != CAPTURE)
                err_overrun_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (vif.VSYNC) begin
                        state_reg <= CAPTURE;
                        row_reg   <= '0;
                        col_reg   <= '0;
                    end
                end
                CAPTURE: begin
                    if (vif.VSYNC) begin
                        row_reg <= '0;
                        col_reg <= '0;
                    end else if (vif.HSYNC) begin
                        if (last_beat) begin
                            state_reg      <= DRAIN;
                            frame_done_reg <= 1'b1;
                            rd_idx_reg     <= '0;
                            q_ok_reg       <= 1'b0;
                            cur_last_reg   <= 1'b0;
                            byte_sel_reg   <= '0;
                            byte_valid_reg <= 1'b0;
                        end else if (col_reg == COL_W'(WIDTH - 2)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + COL_W'(2);
                        end
                    end
                end
                DRAIN: begin
                    if (do_load) begin
                        cur_entry_reg  <= rd_q_reg;
                        byte_sel_reg   <= '0;
                        byte_valid_reg <= 1'b1;
                        q_ok_reg       <= 1'b0;
                        if (rd_idx_reg == IDX_W'(BEATS - 1))
                            cur_last_reg <= 1'b1;
                        else
                            rd_idx_reg <= rd_idx_reg + 1'b1;
                    end else begin
                        q_ok_reg <= 1'b1;
                        if (handshake) begin
                            if (byte_sel_reg != 3'd5) begin
                                byte_sel_reg <= byte_sel_reg + 3'd1;
                            end else if (cur_last_reg) begin
                                byte_valid_reg <= 1'b0;
                                drain_done_reg <= 1'b1;
                                state_reg      <= IDLE;
                                rd_idx_reg     <= '0;
                                cur_last_reg   <= 1'b0;
                                byte_sel_reg   <= '0;
                            end else begin
                                byte_valid_reg <= 1'b0;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (byte_sel_reg)
            3'd0:    byte_mux = cur_entry_reg[47:40];
            3'd1:    byte_mux = cur_entry_reg[39:32];
            3'd2:    byte_mux = cur_entry_reg[31:24];
            3'd3:    byte_mux = cur_entry_reg[23:16];
            3'd4:    byte_mux = cur_entry_reg[15:8];
            default: byte_mux = cur_entry_reg[7:0];
        endcase
    end

    assign vif.byte_out    = byte_valid_reg ? byte_mux : 8'd0;
    assign vif.byte_valid  = byte_valid_reg;
    assign vif.frame_done  = frame_done_reg;
    assign vif.drain_done  = drain_done_reg;
    assign vif.err_overrun = err_overrun_reg;
endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write with a 4x2 frame: capture, bottom-up drain, stalls, gaps, restart, errors, reset.
`timescale 1ns/1ps
module tb_image_write;
    logic HCLK;
    logic HRESETn;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q [0:23];

    image_write_if vif();

    image_write #(.WIDTH(4), .HEIGHT(2)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .vif     (vif)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_beat(input int p, input bit junk);
        vif.HSYNC   = 1'b1;
        vif.DATA_R0 = junk ? 8'hEE : 8'(p);
        vif.DATA_G0 = junk ? 8'hEE : 8'(p + 16);
        vif.DATA_B0 = junk ? 8'hEE : 8'(p + 32);
        vif.DATA_R1 = junk ? 8'hEE : 8'(p + 1);
        vif.DATA_G1 = junk ? 8'hEE : 8'(p + 17);
        vif.DATA_B1 = junk ? 8'hEE : 8'(p + 33);
    endtask

    // VSYNC pulse then four beats (p = row*4+col); returns one cycle after the last beat's edge
    task automatic send_frame(input int gap);
        bit last;
        vif.VSYNC = 1'b1;
        tick();
        vif.VSYNC = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c += 2) begin
                set_beat(r * 4 + c, 1'b0);
                tick();
                vif.HSYNC = 1'b0;
                last = (r == 1) && (c == 2);
                check(last ? "frame_done_hi" : "frame_done_lo", vif.frame_done, last);
                if (!last)
                    repeat (gap) tick();
            end
        end
    endtask

    task automatic collect(input bit toggle, input bit inject, input int abort_at);
        int got = 0;
        int dd = 0;
        int post = 0;
        bit stalled = 1'b0;
        bit ready;
        logic [7:0] held = 8'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (vif.drain_done) dd++;
            if (stalled) begin
                check("stall_valid", vif.byte_valid, 1'b1);
                check("stall_stable", vif.byte_out, held);
            end
            if (abort_at > 0 && got == abort_at - 1 && vif.byte_valid) begin
                HRESETn = 1'b0;
                #1;
                check("rst_byte_valid", vif.byte_valid, 1'b0);
                check("rst_byte_out", vif.byte_out, 8'd0);
                check("rst_frame_done", vif.frame_done, 1'b0);
                check("rst_drain_done", vif.drain_done, 1'b0);
                check("rst_err", vif.err_overrun, 1'b0);
                return;
            end
            ready = toggle ? (cyc % 2 == 0) : 1'b1;
            vif.byte_ready = ready;
            stalled = 1'b0;
            if (vif.byte_valid) begin
                if (ready) begin
                    if (got < 24) check($sformatf("byte%0d", got), vif.byte_out, exp_q[got]);
                    else          check("extra_byte", 1'b1, 1'b0);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held = vif.byte_out;
                end
            end
            if (inject) begin
                if (cyc == 5) set_beat(0, 1'b1);
                if (cyc == 6) begin vif.HSYNC = 1'b0; vif.VSYNC = 1'b1; end
                if (cyc == 7) vif.VSYNC = 1'b0;
            end
            tick();
            if (got >= 24) post++;
            if (post >= 5) break;
        end
        vif.byte_ready = 1'b1;
        check("byte_count", got, 24);
        check("drain_done_once", dd, 1);
        check("valid_after_drain", vif.byte_valid, 1'b0);
    endtask

    initial begin
        int k;
        bit any_valid;
        k = 0;
        for (int r = 1; r >= 0; r--)
            for (int c = 0; c < 4; c++) begin
                exp_q[k]     = 8'(r * 4 + c);
                exp_q[k + 1] = 8'(r * 4 + c + 16);
                exp_q[k + 2] = 8'(r * 4 + c + 32);
                k += 3;
            end

        vif.VSYNC = 1'b0; vif.HSYNC = 1'b0; vif.byte_ready = 1'b1;
        vif.DATA_R0 = 8'd0; vif.DATA_G0 = 8'd0; vif.DATA_B0 = 8'd0;
        vif.DATA_R1 = 8'd0; vif.DATA_G1 = 8'd0; vif.DATA_B1 = 8'd0;
        HRESETn = 1'b0;
        repeat (3) tick();

        // 1: reset state, idle with ready asserted
        check("reset_byte_valid", vif.byte_valid, 1'b0);
        check("reset_byte_out", vif.byte_out, 8'd0);
        check("reset_frame_done", vif.frame_done, 1'b0);
        check("reset_drain_done", vif.drain_done, 1'b0);
        check("reset_err", vif.err_overrun, 1'b0);
        HRESETn = 1'b1;
        any_valid = 1'b0;
        repeat (20) begin tick(); if (vif.byte_valid) any_valid = 1'b1; end
        check("idle_no_valid", any_valid, 1'b0);

        // 2: back-to-back frame, latency to first byte, full stream
        send_frame(0);
        check("lat_cycle0", vif.byte_valid, 1'b0);
        tick();
        check("lat_cycle1", vif.byte_valid, 1'b0);
        check("frame_done_pulse", vif.frame_done, 1'b0);
        tick();
        check("lat_cycle2", vif.byte_valid, 1'b1);
        check("first_byte", vif.byte_out, 8'h04);
        collect(1'b0, 1'b0, 0);

        // 3: ready toggling
        send_frame(0);
        collect(1'b1, 1'b0, 0);

        // 4: gapped beats, then restart after a partial frame
        send_frame(3);
        collect(1'b0, 1'b0, 0);
        vif.VSYNC = 1'b1; tick(); vif.VSYNC = 1'b0;
        set_beat(0, 1'b1); tick();
        set_beat(0, 1'b1); tick();
        vif.HSYNC = 1'b0;
        send_frame(0);
        collect(1'b0, 1'b0, 0);
        check("err_clear_before_5", vif.err_overrun, 1'b0);

        // 5: overrun during drain and in idle
        send_frame(0);
        collect(1'b0, 1'b1, 0);
        check("err_from_drain", vif.err_overrun, 1'b1);
        set_beat(0, 1'b1); tick(); vif.HSYNC = 1'b0; tick();
        check("err_sticky", vif.err_overrun, 1'b1);
        HRESETn = 1'b0; tick(); HRESETn = 1'b1; tick();
        check("err_cleared_by_reset", vif.err_overrun, 1'b0);
        set_beat(0, 1'b1); tick(); vif.HSYNC = 1'b0; tick();
        check("err_from_idle", vif.err_overrun, 1'b1);
        HRESETn = 1'b0; tick(); HRESETn = 1'b1; tick();

        // 6: reset at the 10th drained byte, then a clean frame
        send_frame(0);
        collect(1'b0, 1'b0, 10);
        repeat (2) tick();
        HRESETn = 1'b1;
        any_valid = 1'b0;
        repeat (10) begin tick(); if (vif.byte_valid || vif.drain_done) any_valid = 1'b1; end
        check("no_partial_drain", any_valid, 1'b0);
        send_frame(0);
        collect(1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
